// File: rtl/vec_exec_wb.sv
// Purpose : 4-lane vector execute / memory / write-back back end with loop-counter ALU and vector store.
// Latency : op at ID/EX in cycle N -> memWE in N+1 -> regWriteWB/res* in N+2; one op per cycle.
// Backpr. : stall freezes EX/MEM and MEM/WB and masks every write strobe; upstream holds its op.
//
// Ports:
//   clk, rst (async, active high), stall
//   RD01E..RD31E / RD02E..RD32E : lane 0..3 operands A / B
//   dataOp1 (counter limit), dataOp2 (current counter), RdE, regWriteE, memWriteE, updateCnt, aluControlE
//   regWriteWB, RdestW, res0..res3      : lane register-file write back
//   updateCount, resCount, zeroFlag     : counter register file / hazard unit
//   memWE, memAddr, memWData            : vector store (lane 3 in MSBs)
// Build option: define VEC_ROTATE_EN to enable the rotl/rotr opcodes (101/110). When undefined those
// opcodes yield 0 and never write the register file; the rotate datapath is not built.
module vec_exec_wb #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [DATA_W-1:0]     RD01E,
    input  logic [DATA_W-1:0]     RD11E,
    input  logic [DATA_W-1:0]     RD21E,
    input  logic [DATA_W-1:0]     RD31E,
    input  logic [DATA_W-1:0]     RD02E,
    input  logic [DATA_W-1:0]     RD12E,
    input  logic [DATA_W-1:0]     RD22E,
    input  logic [DATA_W-1:0]     RD32E,
    input  logic [DATA_W-1:0]     dataOp1,
    input  logic [DATA_W-1:0]     dataOp2,
    input  logic [3:0]            RdE,
    input  logic                  regWriteE,
    input  logic                  memWriteE,
    input  logic                  updateCnt,
    input  logic [2:0]            aluControlE,
    output logic                  regWriteWB,
    output logic [3:0]            RdestW,
    output logic [DATA_W-1:0]     res0,
    output logic [DATA_W-1:0]     res1,
    output logic [DATA_W-1:0]     res2,
    output logic [DATA_W-1:0]     res3,
    output logic                  updateCount,
    output logic [DATA_W-1:0]     resCount,
    output logic                  zeroFlag,
    output logic                  memWE,
    output logic [MEM_AW-1:0]     memAddr,
    output logic [4*DATA_W-1:0]   memWData
);

    localparam int LANES = 4;

    // Fields that travel all the way to write-back.
    typedef struct packed {
        logic [LANES-1:0][DATA_W-1:0] res;
        logic [3:0]                   rd;
        logic                         reg_write;
        logic                         upd;
        logic [DATA_W-1:0]            cnt;
    } wb_t;

    // EX/MEM additionally carries the store request.
    typedef struct packed {
        wb_t                     wb;
        logic                    mem_write;
        logic [MEM_AW-1:0]       addr;
        logic [LANES*DATA_W-1:0] wdata;
    } exmem_t;

    function automatic logic [DATA_W-1:0] lane_alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
`ifdef VEC_ROTATE_EN
        logic [2*DATA_W-1:0] dbl;
        dbl = '0;
`endif
        lane_alu = '0;
        case (op)
            3'b000: lane_alu = a + b;
            3'b001: lane_alu = a - b;
            3'b010: lane_alu = a ^ b;
            3'b011: lane_alu = a & b;
            3'b100: lane_alu = a | b;
`ifdef VEC_ROTATE_EN
            // Rotate by shifting a doubled copy; the wanted half holds the wrapped bits.
            3'b101: begin
                dbl      = {a, a} << b[3:0];
                lane_alu = dbl[2*DATA_W-1:DATA_W];
            end
            3'b110: begin
                dbl      = {a, a} >> b[3:0];
                lane_alu = dbl[DATA_W-1:0];
            end
`endif
            3'b111: lane_alu = b;
            default: lane_alu = '0;
        endcase
    endfunction

    logic [LANES-1:0][DATA_W-1:0] op_a;
    logic [LANES-1:0][DATA_W-1:0] op_b;
    logic [LANES-1:0][DATA_W-1:0] alu_res;
    logic [DATA_W-1:0]            cnt_next;
    logic                         reg_write_ok;
    exmem_t                       exmem_d;
    exmem_t                       exmem_q;
    wb_t                          memwb_q;
    logic                         zero_q;

    assign op_a     = {RD31E, RD21E, RD11E, RD01E};
    assign op_b     = {RD32E, RD22E, RD12E, RD02E};
    assign cnt_next = dataOp2 - DATA_W'(1);

`ifdef VEC_ROTATE_EN
    assign reg_write_ok = regWriteE;
`else
    // Unsupported rotate opcodes must never corrupt the register file.
    assign reg_write_ok = regWriteE & ~((aluControlE == 3'b101) || (aluControlE == 3'b110));
`endif

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_res[i] = lane_alu(aluControlE, op_a[i], op_b[i]);
        end
    end

    always_comb begin
        exmem_d              = '0;
        exmem_d.wb.res       = alu_res;
        exmem_d.wb.rd        = RdE;
        exmem_d.wb.reg_write = reg_write_ok;
        exmem_d.wb.upd       = updateCnt;
        exmem_d.wb.cnt       = cnt_next;
        exmem_d.mem_write    = memWriteE;
        exmem_d.addr         = RD01E[MEM_AW-1:0];
        exmem_d.wdata        = op_b;
    end

    // Both pipeline registers and the zero flag advance only on non-stalled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_q <= '0;
            memwb_q <= '0;
            zero_q  <= 1'b0;
        end else if (!stall) begin
            exmem_q <= exmem_d;
            memwb_q <= exmem_q.wb;
            if (updateCnt) begin
                zero_q <= (cnt_next == '0) || (cnt_next == dataOp1);
            end
        end
    end

    // Strobes are masked while stalled so a held op fires exactly once, after release.
    assign memWE       = exmem_q.mem_write & ~stall;
    assign memAddr     = exmem_q.addr;
    assign memWData    = exmem_q.wdata;

    assign regWriteWB  = memwb_q.reg_write & ~stall;
    assign RdestW      = memwb_q.rd;
    assign res0        = memwb_q.res[0];
    assign res1        = memwb_q.res[1];
    assign res2        = memwb_q.res[2];
    assign res3        = memwb_q.res[3];
    assign updateCount = memwb_q.upd & ~stall;
    assign resCount    = memwb_q.cnt;
    assign zeroFlag    = zero_q;

endmodule
